// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port, fixed-latency unified memory between the
//            fetch stage and the memory stage. Data requests win by default;
//            a starvation counter forces a fetch grant after STARVE_LIMIT
//            consecutive losses. One transaction is in flight at a time.
// Ports    : clk_i / rst_i         clock, synchronous active-low reset
//            ifetch_*              fetch requester (read only)
//            dmem_*                data requester (read / write)
//            mem_*                 shared memory macro interface
//            stall_fetch_o/mem_o   per-requester stalls for hazard logic
//            busy_o                high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ifetch_req_i,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr_i,
  output logic [DATA_WIDTH-1:0] ifetch_rdata_o,
  output logic                  ifetch_valid_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_valid_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_fetch_o,
  output logic                  stall_mem_o,
  output logic                  busy_o
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(MEM_LATENCY + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WC_W-1:0] WAIT_LOAD  = WC_W'(MEM_LATENCY);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q,        state_d;
  logic [SC_W-1:0]       starve_cnt_q,   starve_cnt_d;
  logic [WC_W-1:0]       wait_cnt_q,     wait_cnt_d;
  logic                  owner_data_q,   owner_data_d;
  logic                  we_q,           we_d;
  logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,        wdata_d;
  logic [DATA_WIDTH-1:0] ifetch_rdata_q, ifetch_rdata_d;
  logic [DATA_WIDTH-1:0] dmem_rdata_q,   dmem_rdata_d;

  always_comb begin
    state_d        = state_q;
    starve_cnt_d   = starve_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    owner_data_d   = owner_data_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    ifetch_rdata_d = ifetch_rdata_q;
    dmem_rdata_d   = dmem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!ifetch_req_i) begin
          starve_cnt_d = '0;
        end
        if (ifetch_req_i || dmem_req_i) begin
          // Data wins unless fetch has already lost STARVE_LIMIT times in a row.
          if (dmem_req_i && !(ifetch_req_i && (starve_cnt_q == STARVE_MAX))) begin
            owner_data_d = 1'b1;
            we_d         = dmem_we_i;
            addr_d       = dmem_addr_i;
            wdata_d      = dmem_wdata_i;
            // Reaching this branch with fetch pending implies starve_cnt_q is
            // below the limit, so the increment cannot overflow.
            if (ifetch_req_i) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end else begin
            owner_data_d = 1'b0;
            we_d         = 1'b0;
            addr_d       = ifetch_addr_i;
            starve_cnt_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == WAIT_LAST) begin
          if (owner_data_q) begin
            dmem_rdata_d = mem_rdata_i;
          end else begin
            ifetch_rdata_d = mem_rdata_i;
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // No arbitration here: a requester still holding req is re-served
        // only after the FSM passes through IDLE again.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= ST_IDLE;
      starve_cnt_q   <= '0;
      wait_cnt_q     <= '0;
      owner_data_q   <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      ifetch_rdata_q <= '0;
      dmem_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      owner_data_q   <= owner_data_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      ifetch_rdata_q <= ifetch_rdata_d;
      dmem_rdata_q   <= dmem_rdata_d;
    end
  end

  assign mem_req_o      = (state_q == ST_ISSUE);
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign ifetch_valid_o = (state_q == ST_RESP) && !owner_data_q;
  assign dmem_valid_o   = (state_q == ST_RESP) &&  owner_data_q;
  assign ifetch_rdata_o = ifetch_rdata_q;
  assign dmem_rdata_o   = dmem_rdata_q;
  assign stall_fetch_o  = ifetch_req_i & ~ifetch_valid_o;
  assign stall_mem_o    = dmem_req_i & ~dmem_valid_o;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port, fixed-latency unified memory between the pipeline's fetch stage and memory stage. Data-side requests win by default; a starvation guard bounds how long fetch can be locked out. The block generates per-requester stall signals for the hazard logic. It sits between `pc_reg`/`pip_reg_d` (fetch side), `pip_reg_m` (data side) and the shared memory macro.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of both ports and the memory.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 2, cycles from the `mem_req_o` cycle to valid `mem_rdata_i`. Minimum 1.
- STARVE_LIMIT, 3, consecutive lost arbitrations after which fetch is forced to win. Minimum 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- ifetch_req_i  in  1  fetch request; level, held until `ifetch_valid_o`.
- ifetch_addr_i  in  ADDR_WIDTH  fetch address.
- ifetch_rdata_o  out  DATA_WIDTH  fetch read data; valid when `ifetch_valid_o` is high.
- ifetch_valid_o  out  1  one-cycle completion pulse for fetch.
- dmem_req_i  in  1  data request; level, held until `dmem_valid_o`.
- dmem_we_i  in  1  1 = write, 0 = read.
- dmem_addr_i  in  ADDR_WIDTH  data address.
- dmem_wdata_i  in  DATA_WIDTH  write data.
- dmem_rdata_o  out  DATA_WIDTH  data read data.
- dmem_valid_o  out  1  one-cycle completion pulse for data.
- mem_req_o  out  1  memory access strobe; exactly one cycle per transaction.
- mem_we_o  out  1  memory write enable; qualified by `mem_req_o`.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- stall_fetch_o  out  1  `ifetch_req_i & ~ifetch_valid_o`, combinational.
- stall_mem_o  out  1  `dmem_req_i & ~dmem_valid_o`, combinational.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is in flight at a time.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise select the owner:
    - data wins if `dmem_req_i`, unless `ifetch_req_i` is high and `starve_cnt == STARVE_LIMIT`;
    - fetch wins if it is the only requester.
  - Latch owner, address, we and wdata; go to ISSUE.
- **Starvation counter** (`starve_cnt`), updated only on IDLE arbitration edges:
  - +1 when fetch requests but data wins, saturating at STARVE_LIMIT;
  - cleared when fetch wins or fetch is not requesting.
- **ISSUE**
  - Drive `mem_req_o=1` with the latched `mem_we_o`, `mem_addr_o` and `mem_wdata_o`.
  - Write: go to RESP.
  - Read: load the wait counter with MEM_LATENCY and go to WAIT.
- **WAIT**
  - `mem_req_o=0`; the counter decrements each cycle.
  - At the edge where the counter equals 1: capture `mem_rdata_i` into the owner's rdata register and go to RESP.
- **RESP**
  - The owner's `*_valid_o=1` for exactly one cycle, then IDLE. No arbitration happens in RESP.
  - Because of this, a requester still holding `req` during its valid cycle is not re-served.
- **Write completion:** `dmem_rdata_o` keeps its previous value.
- **`mem_*_o` in non-ISSUE cycles:** address, data and we hold their last values and are don't-care.
- **Request dropped mid-transaction** (e.g. fetch flushed on PCSrcE): the transaction completes and the valid pulse still fires. The requester ignores it.
- **Request held across RESP with a changed address:** served as a new transaction after IDLE.
- A fetch requester never sets `we`; the fetch port has no write path.

## Timing
- Reset (`rst_i=0` at an edge), including mid-transaction:
  - state → IDLE; `starve_cnt`=0; wait counter = 0;
  - `mem_req_o`, `mem_we_o`, both valids = 0;
  - both rdata registers, `mem_addr_o`, `mem_wdata_o` = 0.
  - An in-flight transaction is abandoned with no valid pulse.
- Read latency: request sampled in IDLE at cycle 0 → ISSUE cycle 1 → WAIT cycles 2..MEM_LATENCY+1 → valid in cycle MEM_LATENCY+2 (cycle 4 for the default).
- Write latency: request in cycle 0 → ISSUE cycle 1 → valid in cycle 2.
- Throughput: one read per MEM_LATENCY+3 cycles; one write per 3 cycles.
- Simultaneous `ifetch_req_i` and `dmem_req_i` in IDLE: the losing requester's stall stays high through the whole winning transaction plus its own.

## Test plan
- **Lone fetch read.** Reset, then `ifetch_req_i=1`, addr 0x100, memory model returns 0xDEADBEEF at latency 2.
  - `mem_req_o` high only in cycle 1 with addr 0x100.
  - `ifetch_valid_o` high only in cycle 4 with `ifetch_rdata_o`=0xDEADBEEF.
  - `stall_fetch_o` high cycles 0–3.
- **Data write.** `dmem_req_i=1`, we=1, addr 0x10000, wdata 0x5A.
  - cycle 1: `mem_req_o=1`, `mem_we_o=1`, 0x10000 / 0x5A.
  - `dmem_valid_o` in cycle 2.
  - `dmem_rdata_o` unchanged.
- **Contention.** Both requests high continuously, data re-requesting each time with write addresses.
  - First three grants go to data, fourth to fetch (STARVE_LIMIT=3).
  - `starve_cnt` clears after the fetch grant.
- **Dropped request.** Fetch read issued, then `ifetch_req_i` deasserted during WAIT.
  - `ifetch_valid_o` still pulses in cycle 4.
  - Next IDLE arbitration serves a pending data request.
- **Reset mid-WAIT.** `rst_i=0` for one edge in cycle 2 of a read.
  - Next cycle: all outputs at reset values, no valid pulse.
  - A fresh request afterwards completes normally.
- **Back-to-back.** Fetch holds req through RESP and changes addr 0x100 → 0x104 after valid.
  - Exactly two `mem_req_o` pulses, at cycles 1 and 6, with addresses 0x100 and 0x104.
